// File: rtl/tlul_pkg.sv
// TL-UL types shared by the response-side integrity checker.
package tlul_pkg;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Fields covered by the response integrity code.
  typedef struct packed {
    tl_d_op_e   opcode;
    logic [1:0] size;
    logic       error;
  } tl_d2h_rsp_intg_t;

  typedef enum logic [1:0] {
    RspChkIdle   = 2'b00,
    RspChkAlert  = 2'b01,
    RspChkLocked = 2'b10
  } tlul_rsp_chk_state_e;

  function automatic tl_d2h_rsp_intg_t extract_d2h_rsp_intg(tl_d2h_t tl);
    tl_d2h_rsp_intg_t rsp;
    rsp.opcode = tl.d_opcode;
    rsp.size   = tl.d_size;
    rsp.error  = tl.d_error;
    return rsp;
  endfunction

endpackage

// File: rtl/prim_secded_39_32_enc.sv
// Hsiao SECDED(39,32) encoder: data in [31:0], check bits in [38:32].
module prim_secded_39_32_enc (
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  logic [38:0] ext;

  always_comb begin
    ext         = 39'(data_i);
    data_o      = ext;
    data_o[32]  = ^(ext & 39'h002606BD25);
    data_o[33]  = ^(ext & 39'h00DEBA8050);
    data_o[34]  = ^(ext & 39'h00413D89AA);
    data_o[35]  = ^(ext & 39'h0031234ED1);
    data_o[36]  = ^(ext & 39'h00C2C1323B);
    data_o[37]  = ^(ext & 39'h002DCC624C);
    data_o[38]  = ^(ext & 39'h0098505586);
  end

endmodule

// File: rtl/prim_secded_64_57_enc.sv
// Hsiao SECDED(64,57) encoder: data in [56:0], check bits in [63:57].
module prim_secded_64_57_enc (
  input  logic [56:0] data_i,
  output logic [63:0] data_o
);

  logic [63:0] ext;

  always_comb begin
    ext         = 64'(data_i);
    data_o      = ext;
    data_o[57]  = ^(ext & 64'h0103FFF800007FFF);
    data_o[58]  = ^(ext & 64'h017C1FF801FF801F);
    data_o[59]  = ^(ext & 64'h01BDE1F87E0781E1);
    data_o[60]  = ^(ext & 64'h01DEEE3B8E388E22);
    data_o[61]  = ^(ext & 64'h01EF76CDB2C93244);
    data_o[62]  = ^(ext & 64'h01F7BB56D5525488);
    data_o[63]  = ^(ext & 64'h01FBDDA769A46910);
  end

endmodule

// File: rtl/tlul_rsp_intg_chk.sv
// Checks TL-UL response integrity on accepted beats, raises a fatal alert and counts errors.
// Define TLUL_RSP_DATA_INTG_CHK_EN to also check data integrity of AccessAckData beats.
module tlul_rsp_intg_chk
  import tlul_pkg::*;
#(
  parameter int unsigned ErrCntW = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tl_d2h_t            tl_i,
  input  logic               d_ready_i,
  output tl_d2h_t            tl_o,
  output logic               rsp_err_o,
  output logic               alert_req_o,
  input  logic               alert_ack_i,
  output logic               fault_o,
  input  logic               clr_cnt_i,
  output logic [ErrCntW-1:0] err_cnt_o
);

  localparam logic [ErrCntW-1:0] CntMax = '1;

  tl_d2h_rsp_intg_t    rsp_fields;
  logic [63:0]         rsp_enc;
  logic                accepted;
  logic                rsp_mismatch;
  logic                data_mismatch;
  logic                err_d, err_q;
  tlul_rsp_chk_state_e state_d, state_q;
  logic [ErrCntW-1:0]  err_cnt_d, err_cnt_q;

  always_comb rsp_fields = extract_d2h_rsp_intg(tl_i);

  prim_secded_64_57_enc u_rsp_enc (
    .data_i (57'(rsp_fields)),
    .data_o (rsp_enc)
  );

  // Comparing the full codeword keeps every encoder output bit in use; data bits always match.
  always_comb rsp_mismatch = (rsp_enc != {tl_i.d_user.rsp_intg, 57'(rsp_fields)});

`ifdef TLUL_RSP_DATA_INTG_CHK_EN
  logic [38:0] data_enc;

  prim_secded_39_32_enc u_data_enc (
    .data_i (tl_i.d_data),
    .data_o (data_enc)
  );

  always_comb data_mismatch = (tl_i.d_opcode == AccessAckData) &&
                              (data_enc != {tl_i.d_user.data_intg, tl_i.d_data});
`else
  always_comb data_mismatch = 1'b0;
`endif

  always_comb begin
    accepted = tl_i.d_valid & d_ready_i;
    err_d    = accepted & (rsp_mismatch | data_mismatch);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RspChkIdle:   if (err_q) state_d = RspChkAlert;
      RspChkAlert:  if (alert_ack_i) state_d = RspChkLocked;
      RspChkLocked: state_d = RspChkLocked;
      default:      state_d = RspChkLocked;
    endcase
  end

  // A clear coinciding with a registered error leaves that error counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt_i) begin
      err_cnt_d = err_q ? ErrCntW'(1) : '0;
    end else if (err_q && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + ErrCntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      state_q   <= RspChkIdle;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    rsp_err_o   = err_q;
    alert_req_o = (state_q == RspChkAlert);
    fault_o     = (state_q != RspChkIdle);
    err_cnt_o   = err_cnt_q;
    tl_o        = tl_i;
    if (fault_o) tl_o.d_error = 1'b1;
  end

endmodule

// File: tb/tb_tlul_rsp_intg_chk.sv
// Self-checking bench for tlul_rsp_intg_chk: directed pins plus randomized traffic against a behavioural model.
module tb_tlul_rsp_intg_chk;
  import tlul_pkg::*;

  localparam int unsigned CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  tl_d2h_t       tl_i;
  logic          d_ready;
  logic          ack;
  logic          clr;
  tl_d2h_t       tl_o;
  logic          rsp_err;
  logic          alert_req;
  logic          fault;
  logic [CW-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit m_err_pend = 1'b0;
  bit m_alert    = 1'b0;
  bit m_locked   = 1'b0;
  int m_cnt      = 0;

  always #5 clk = ~clk;

  tlul_rsp_intg_chk #(.ErrCntW(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_i        (tl_i),
    .d_ready_i   (d_ready),
    .tl_o        (tl_o),
    .rsp_err_o   (rsp_err),
    .alert_req_o (alert_req),
    .alert_ack_i (ack),
    .fault_o     (fault),
    .clr_cnt_i   (clr),
    .err_cnt_o   (err_cnt)
  );

  function automatic logic [6:0] ref_rsp_intg(logic [56:0] p);
    logic [63:0] masks [7];
    logic [6:0]  r;
    masks[0] = 64'h0103FFF800007FFF;
    masks[1] = 64'h017C1FF801FF801F;
    masks[2] = 64'h01BDE1F87E0781E1;
    masks[3] = 64'h01DEEE3B8E388E22;
    masks[4] = 64'h01EF76CDB2C93244;
    masks[5] = 64'h01F7BB56D5525488;
    masks[6] = 64'h01FBDDA769A46910;
    for (int k = 0; k < 7; k++) begin
      logic par;
      par = 1'b0;
      for (int b = 0; b < 57; b++) if (masks[k][b] && p[b]) par = ~par;
      r[k] = par;
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_data_intg(logic [31:0] d);
    logic [38:0] masks [7];
    logic [6:0]  r;
    masks[0] = 39'h002606BD25;
    masks[1] = 39'h00DEBA8050;
    masks[2] = 39'h00413D89AA;
    masks[3] = 39'h0031234ED1;
    masks[4] = 39'h00C2C1323B;
    masks[5] = 39'h002DCC624C;
    masks[6] = 39'h0098505586;
    for (int k = 0; k < 7; k++) begin
      logic par;
      par = 1'b0;
      for (int b = 0; b < 32; b++) if (masks[k][b] && d[b]) par = ~par;
      r[k] = par;
    end
    return r;
  endfunction

  function automatic bit beat_bad(tl_d2h_t t);
    bit b;
    b = (ref_rsp_intg(57'({t.d_opcode, t.d_size, t.d_error})) != t.d_user.rsp_intg);
`ifdef TLUL_RSP_DATA_INTG_CHK_EN
    if (t.d_opcode == AccessAckData && ref_data_intg(t.d_data) != t.d_user.data_intg) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic tl_d2h_t mk_beat(tl_d_op_e op, logic [1:0] sz, logic er, logic [31:0] data);
    tl_d2h_t t;
    t                  = '0;
    t.d_valid          = 1'b1;
    t.d_opcode         = op;
    t.d_size           = sz;
    t.d_error          = er;
    t.d_data           = data;
    t.d_user.rsp_intg  = ref_rsp_intg(57'({op, sz, er}));
    t.d_user.data_intg = ref_data_intg(data);
    return t;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs sampled at a rising edge.
  task automatic model_edge();
    if (rst) begin
      m_err_pend = 1'b0;
      m_alert    = 1'b0;
      m_locked   = 1'b0;
      m_cnt      = 0;
      return;
    end
    if (clr) m_cnt = m_err_pend ? 1 : 0;
    else if (m_err_pend) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    if (m_alert && ack) begin
      m_alert  = 1'b0;
      m_locked = 1'b1;
    end else if (!m_alert && !m_locked && m_err_pend) begin
      m_alert = 1'b1;
    end
    m_err_pend = tl_i.d_valid && d_ready && beat_bad(tl_i);
  endtask

  task automatic compare_all();
    tl_d2h_t exp_o;
    exp_o = tl_i;
    if (m_alert || m_locked) exp_o.d_error = 1'b1;
    chk("rsp_err", 128'(rsp_err), 128'(m_err_pend));
    chk("alert_req", 128'(alert_req), 128'(m_alert));
    chk("fault", 128'(fault), 128'(m_alert || m_locked));
    chk("err_cnt", 128'(err_cnt), 128'(m_cnt));
    chk("tl_o", 128'(tl_o), 128'(exp_o));
  endtask

  always @(posedge clk) begin
    model_edge();
    #1;
    compare_all();
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    tl_i    = '0;
    d_ready = 1'b1;
    ack     = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  tl_d2h_t good_b, bad_b, t;

  initial begin
    idle();
    #1 rst = 1'b1;
    #1;
    chk("rst_rsp_err", 128'(rsp_err), 128'(0));
    chk("rst_alert", 128'(alert_req), 128'(0));
    chk("rst_fault", 128'(fault), 128'(0));
    chk("rst_cnt", 128'(err_cnt), 128'(0));
    cyc();
    cyc();
    rst = 1'b0;

    // Known codeword: AccessAck, size 2, no error
    chk("pin_rsp_intg", 128'(ref_rsp_intg(57'h4)), 128'(7'h13));
    good_b = mk_beat(AccessAck, 2'd2, 1'b0, 32'h0);
    chk("pin_good_beat_intg", 128'(good_b.d_user.rsp_intg), 128'(7'h13));
    bad_b = good_b;
    bad_b.d_user.rsp_intg[0] = ~bad_b.d_user.rsp_intg[0];

    tl_i = good_b;
    #1 chk("good_tl_o_passthru", 128'(tl_o), 128'(good_b));
    cyc();
    idle();
    chk("good_no_err", 128'(rsp_err), 128'(0));
    cyc();
    chk("good_cnt0", 128'(err_cnt), 128'(0));

    // Bad response integrity
    tl_i = bad_b;
    cyc();
    idle();
    chk("bad_pulse", 128'(rsp_err), 128'(1));
    chk("bad_cnt_before", 128'(err_cnt), 128'(0));
    cyc();
    chk("bad_alert", 128'(alert_req), 128'(1));
    chk("bad_fault", 128'(fault), 128'(1));
    chk("bad_cnt1", 128'(err_cnt), 128'(1));
    chk("bad_pulse_gone", 128'(rsp_err), 128'(0));
    chk("bad_forced_derr", 128'(tl_o.d_error), 128'(1));

    // Ack together with a second bad beat
    ack  = 1'b1;
    tl_i = bad_b;
    cyc();
    idle();
    chk("ack_alert_low", 128'(alert_req), 128'(0));
    chk("ack_fault", 128'(fault), 128'(1));
    cyc();
    chk("ack_cnt2", 128'(err_cnt), 128'(2));

    // Saturation at 3
    clr = 1'b1;
    cyc();
    idle();
    chk("clr_cnt0", 128'(err_cnt), 128'(0));
    tl_i = bad_b;
    repeat (5) cyc();
    idle();
    cyc();
    cyc();
    chk("sat_cnt3", 128'(err_cnt), 128'(3));

    // Clear with a registered error in the same cycle
    tl_i = bad_b;
    cyc();
    idle();
    clr = 1'b1;
    cyc();
    idle();
    chk("clr_with_err", 128'(err_cnt), 128'(1));

    // Clear together with a bad beat
    clr  = 1'b1;
    tl_i = bad_b;
    cyc();
    idle();
    chk("clr_beat_cnt0", 128'(err_cnt), 128'(0));
    cyc();
    chk("clr_beat_cnt1", 128'(err_cnt), 128'(1));

    // Bad beat stalled by d_ready
    do_reset();
    tl_i    = bad_b;
    d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_no_err", 128'(rsp_err), 128'(0));
    end
    d_ready = 1'b1;
    cyc();
    idle();
    chk("stall_accept_err", 128'(rsp_err), 128'(1));
    cyc();
    cyc();
    chk("stall_cnt1", 128'(err_cnt), 128'(1));
    chk("stall_alert", 128'(alert_req), 128'(1));

    // Reset asserted mid-ALERT with a pending error
    tl_i = bad_b;
    cyc();
    idle();
    #1 rst = 1'b1;
    #1;
    chk("async_alert", 128'(alert_req), 128'(0));
    chk("async_fault", 128'(fault), 128'(0));
    chk("async_rsp_err", 128'(rsp_err), 128'(0));
    chk("async_cnt", 128'(err_cnt), 128'(0));
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("pend_discarded", 128'(err_cnt), 128'(0));
    chk("pend_no_fault", 128'(fault), 128'(0));

    // AccessAckData with corrupted data integrity
    t = mk_beat(AccessAckData, 2'd2, 1'b0, 32'hDEADBEEF);
    t.d_user.data_intg[3] = ~t.d_user.data_intg[3];
    tl_i = t;
    cyc();
    idle();
`ifdef TLUL_RSP_DATA_INTG_CHK_EN
    chk("data_intg_err", 128'(rsp_err), 128'(1));
`else
    chk("data_intg_ignored", 128'(rsp_err), 128'(0));
`endif

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      t = mk_beat(($urandom_range(1) == 1) ? AccessAckData : AccessAck,
                  2'($urandom_range(3)), 1'($urandom_range(1)), $urandom());
      t.d_valid  = ($urandom_range(1) == 1);
      t.d_param  = 3'($urandom_range(7));
      t.d_source = 8'($urandom_range(255));
      t.d_sink   = 1'($urandom_range(1));
      t.a_ready  = 1'($urandom_range(1));
      if ($urandom_range(9) == 0) t.d_user.rsp_intg ^= 7'(1 << $urandom_range(6));
      if ($urandom_range(9) == 0) t.d_user.data_intg ^= 7'(1 << $urandom_range(6));
      tl_i    = t;
      d_ready = ($urandom_range(3) != 0);
      ack     = ($urandom_range(7) == 0);
      clr     = ($urandom_range(19) == 0);
      rst     = ($urandom_range(149) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlul_rsp_intg_chk.md
TLUL_RSP_INTG_CHK -- requirements
Module: tlul_rsp_intg_chk

Interface
REQ-001 SHALL have parameter ErrCntW, default 8: width of the saturating error counter.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port tl_i  input  tl_d2h_t  response from the integrity-generating stage.
REQ-005 SHALL have port d_ready_i  input  1  host ready; a beat is accepted when tl_i.d_valid & d_ready_i.
REQ-006 SHALL have port tl_o  output  tl_d2h_t  checked response forwarded to the host.
REQ-007 SHALL have port rsp_err_o  output  1  one-cycle pulse for each failing beat.
REQ-008 SHALL have port alert_req_o  output  1  fatal alert request (level).
REQ-009 SHALL have port alert_ack_i  input  1  alert acknowledge.
REQ-010 SHALL have port fault_o  output  1  sticky fault indication.
REQ-011 SHALL have port clr_cnt_i  input  1  synchronous counter clear.
REQ-012 SHALL have port err_cnt_o  output  ErrCntW  saturating count of failing beats.

Function
REQ-013 SHALL form the response payload as 57'({d_opcode, d_size, d_error}), zero-extended, and SECDED-64/57 encode it; the expected rsp_intg is encoded bits [63:57].
REQ-014 SHALL flag a response error on an accepted beat when the expected rsp_intg != tl_i.d_user.rsp_intg.
REQ-015 SHALL not check beats that are not accepted.
REQ-016 SHALL register the error flag, so rsp_err_o asserts exactly one cycle after the failing beat.
REQ-017 SHALL drive tl_o = tl_i combinationally with zero latency, except that tl_o.d_error is forced to 1 while fault_o=1.
REQ-018 SHALL implement a state machine with states IDLE, ALERT and LOCKED.
REQ-019 SHALL transition IDLE->ALERT on a registered error.
REQ-020 SHALL transition ALERT->LOCKED when alert_ack_i=1.
REQ-021 SHALL keep LOCKED as terminal until reset.
REQ-022 SHALL drive alert_req_o=1 only in ALERT.
REQ-023 SHALL drive fault_o=1 in ALERT and LOCKED.
REQ-024 SHALL ignore alert_ack_i outside ALERT.
REQ-025 SHALL make further errors in ALERT or LOCKED count only, with no state change.
REQ-026 SHALL increment err_cnt_o by 1 per registered error, saturating at 2^ErrCntW-1 with no wrap.
REQ-027 SHALL resolve clr_cnt_i together with an error in the same cycle to err_cnt_o=1.
REQ-028 SHALL clear the counter only through clr_cnt_i, never through the state machine.

Reset
REQ-029 SHALL, while rst_i=1 and independent of clk_i, hold state=IDLE, rsp_err_o=0, alert_req_o=0, fault_o=0 and err_cnt_o=0.
REQ-030 SHALL, on reset asserted in ALERT, drop alert_req_o immediately and discard the pending registered error.

Configuration
REQ-031 SHALL, with TLUL_RSP_DATA_INTG_CHK_EN defined, also flag an error on accepted AccessAckData beats whose SECDED-39/32 check bits of d_data != d_user.data_intg; a beat with both a response and a data mismatch counts once.
REQ-032 SHALL, without TLUL_RSP_DATA_INTG_CHK_EN, ignore data_intg entirely and contain no 39/32 encoder.

Structure
REQ-033 SHALL take tl_d2h_t, tl_d2h_rsp_intg_t, tl_d_op_e and extract_d2h_rsp_intg from tlul_pkg; the state enum tlul_rsp_chk_state_e SHALL be added to tlul_pkg.
REQ-034 SHALL instantiate the existing prim_secded_64_57_enc and, under the macro, prim_secded_39_32_enc; no new sub-module.

Verification
REQ-035 SHALL cover: AccessAck, size=2, error=0, correct rsp_intg, accepted -> rsp_err_o=0, err_cnt_o=0, tl_o==tl_i.
REQ-036 SHALL cover: the same beat with rsp_intg bit 0 flipped -> rsp_err_o pulses in cycle +1, state ALERT, alert_req_o=1, err_cnt_o=1, tl_o.d_error=1.
REQ-037 SHALL cover: in ALERT, alert_ack_i=1 together with a second bad beat -> LOCKED, alert_req_o=0, fault_o=1, err_cnt_o=2.
REQ-038 SHALL cover: ErrCntW=2 with 5 bad beats -> err_cnt_o saturates at 3; clr_cnt_i with a bad beat in the same cycle -> err_cnt_o=1.
REQ-039 SHALL cover: a bad beat held with d_ready_i=0 for 3 cycles -> no error until accepted, then exactly one count.
REQ-040 SHALL cover: rst_i asserted mid-ALERT -> alert_req_o=0 and fault_o=0 without a clock edge; with TLUL_RSP_DATA_INTG_CHK_EN, AccessAckData d_data=32'hDEADBEEF with bad data_intg -> error flagged.
